// File: rtl/arb_pkg.sv
// =============================================================================
// Module      : arb_pkg
// Description : Shared types, sizes and round-robin search helper for
//               rr_arbiter_3to8.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns {found, idx}. The scan starts at last+1 with wrap, so the
    // requester at 'last' is the final candidate considered.
    function automatic logic [IDX_W:0] next_rr(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   last
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = last;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = last + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage : arb_pkg

`default_nettype wire

// File: rtl/decoder_3to8.sv
// =============================================================================
// Module      : decoder_3to8
// Description : 3-to-8 line decoder with enable; C is the MSB of the select.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module decoder_3to8 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       en,
    output logic [7:0] y
);

    logic [2:0] w_sel;

    assign w_sel = {c, b, a};

    for (genvar i = 0; i < 8; i++) begin : g_line
        assign y[i] = en & (w_sel == 3'(i));
    end

endmodule : decoder_3to8

`default_nettype wire

// File: rtl/rr_arbiter_3to8.sv
// =============================================================================
// Module      : rr_arbiter_3to8
// Description : Round-robin arbiter for 8 requesters driving a shared
//               3-to-8 decoder through registered select lines.
//               Optional macro ARB_HOLD_TIMEOUT_EN enables MAX_HOLD preemption.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module rr_arbiter_3to8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic [NUM_REQ-1:0] gnt
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (1 << HOLD_W) <= MAX_HOLD) begin : g_bad_param
        $error("rr_arbiter_3to8: MAX_HOLD must be 1..15 and fit in HOLD_W bits");
    end

    state_t           r_state;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic [IDX_W-1:0] r_last;

    logic [IDX_W:0]   w_search;
    logic             w_found;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_timeout;

    assign w_search   = next_rr(req, r_last);
    assign w_found    = w_search[IDX_W];
    assign w_next_idx = w_search[IDX_W-1:0];

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [NUM_REQ-1:0] w_cur_mask;
    logic               w_others;

    assign w_cur_mask = NUM_REQ'(1) << r_gnt_idx;
    assign w_others   = |(req & ~w_cur_mask);
    assign w_timeout  = (r_hold_cnt == c_hold_last) && w_others;
`else
    assign w_timeout  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_last      <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_HOLD_TIMEOUT_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= GRANT;
                        r_gnt_idx   <= w_next_idx;
                        r_gnt_valid <= 1'b1;
                        r_last      <= w_next_idx;
`ifdef ARB_HOLD_TIMEOUT_EN
                        r_hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    // A released grantee has req=0, so any search hit is another requester.
                    if (!req[r_gnt_idx] || w_timeout) begin
                        if (w_found) begin
                            r_gnt_idx   <= w_next_idx;
                            r_last      <= w_next_idx;
`ifdef ARB_HOLD_TIMEOUT_EN
                            r_hold_cnt  <= '0;
`endif
                        end else begin
                            r_state     <= IDLE;
                            r_gnt_valid <= 1'b0;
                        end
                    end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
                        if (r_hold_cnt != c_hold_last) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

    decoder_3to8 u_decoder (
        .a  (r_gnt_idx[0]),
        .b  (r_gnt_idx[1]),
        .c  (r_gnt_idx[2]),
        .en (r_gnt_valid),
        .y  (gnt)
    );

endmodule : rr_arbiter_3to8

`default_nettype wire

// File: tb/tb_rr_arbiter_3to8.sv
// =============================================================================
// Module      : tb_rr_arbiter_3to8
// Description : Directed self-checking bench for rr_arbiter_3to8; follows
//               the ARB_HOLD_TIMEOUT_EN build of the design.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_rr_arbiter_3to8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [7:0] gnt;

    int n_vec;
    int n_err;

    rr_arbiter_3to8 #(
        .MAX_HOLD (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_gnt;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 8'hFF;

        // Reset with all requests pending
        @(negedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h00);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        rst = 1'b0;
        step();
        check("first_idx", 32'(gnt_idx), 32'h0);
        check("first_gnt", 32'(gnt), 32'h01);

        // Fairness / hold with all requests held
        for (int k = 1; k <= 32; k++) begin
            step();
`ifdef ARB_HOLD_TIMEOUT_EN
            exp_gnt = 8'h01 << ((k / 4) % 8);
`else
            exp_gnt = 8'h01;
`endif
            check($sformatf("all_req_k%0d", k), 32'(gnt), 32'(exp_gnt));
        end

        // Sole requester keeps the grant
        do_reset();
        req = 8'h20;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("sole_k%0d", k), 32'(gnt), 32'h20);
        end
        req = 8'h00;
        step();
        check("sole_drop_gnt", 32'(gnt), 32'h00);
        check("sole_drop_valid", 32'(gnt_valid), 32'h0);
        check("sole_drop_idx", 32'(gnt_idx), 32'h5);

        // Release handoff without an idle bubble
        do_reset();
        req = 8'h06;
        step();
        check("handoff_first", 32'(gnt), 32'h02);
        step();
        check("handoff_hold", 32'(gnt), 32'h02);
        req = 8'h04;
        step();
        check("handoff_gnt", 32'(gnt), 32'h04);
        check("handoff_valid", 32'(gnt_valid), 32'h1);

        // Wrap past 7: requester 0 before 6 once 6 was last
        do_reset();
        req = 8'h40;
        step();
        check("wrap_g6", 32'(gnt), 32'h40);
        req = 8'h00;
        step();
        check("wrap_idle", 32'(gnt), 32'h00);
        req = 8'h41;
        step();
        check("wrap_g0", 32'(gnt), 32'h01);
        req = 8'h40;
        step();
        check("wrap_back6", 32'(gnt), 32'h40);

        // Asynchronous reset between edges
        do_reset();
        req = 8'h10;
        step();
        check("async_pre", 32'(gnt), 32'h10);
        #2;
        rst = 1'b1;
        #1;
        check("async_gnt", 32'(gnt), 32'h00);
        check("async_valid", 32'(gnt_valid), 32'h0);
        req = 8'h84;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("async_restart", 32'(gnt_idx), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_arbiter_3to8

`default_nettype wire
